big_packet_builder: RTL and testbench

- Transmit-side counterpart of the on-chip ThinkGear big-packet parser.
- Assembles a 36-byte ThinkGear "big packet" from a latched signal/attention/meditation triple and streams it byte-by-byte into the existing byte-wide UART transmitter.
- Used for loopback self-test of the RS232 receive/parse path and as a headset emulator toward a host PC.
- Generates the frame header, fixed payload codes, EEG-power filler and the trailing checksum.

---
 rtl/big_packet_builder.sv | 142 ++++++++++++++
 tb/tb_big_packet_builder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_packet_builder.sv
// ThinkGear big-packet builder: latches a signal/attention/meditation triple and
// streams the 36-byte frame (header, payload, checksum) into a byte-wide UART.
module big_packet_builder #(
  parameter logic [7:0]  EEG_FILL = 8'h00,
  parameter logic [15:0] ACK_TO   = 16'd1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] signal_in,
  input  logic [7:0] attention_in,
  input  logic [7:0] meditation_in,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StDone, StAbort} state_e;

  localparam logic [5:0] LastIdx = 6'd35;

  state_e      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  sig_q, sig_d;
  logic [7:0]  att_q, att_d;
  logic [7:0]  med_q, med_d;
  logic [15:0] wait_q, wait_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  cur_byte;

  // Frame byte for the current index; index 35 is the inverted payload sum
  always_comb begin
    cur_byte = EEG_FILL;
    case (k_q)
      6'd0, 6'd1: cur_byte = 8'hAA;
      6'd2:       cur_byte = 8'h20;
      6'd3:       cur_byte = 8'h02;
      6'd4:       cur_byte = sig_q;
      6'd5:       cur_byte = 8'h83;
      6'd6:       cur_byte = 8'h18;
      6'd31:      cur_byte = 8'h04;
      6'd32:      cur_byte = att_q;
      6'd33:      cur_byte = 8'h05;
      6'd34:      cur_byte = med_q;
      LastIdx:    cur_byte = ~csum_q;
      default:    cur_byte = EEG_FILL;
    endcase
  end

  // Next-state, byte sequencing, checksum and handshake timeout
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    csum_d     = csum_q;
    sig_d      = sig_q;
    att_d      = att_q;
    med_d      = med_q;
    wait_d     = wait_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (send) begin
          sig_d   = signal_in;
          att_d   = attention_in;
          med_d   = meditation_in;
          k_d     = '0;
          csum_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d = '0;
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          // Only payload bytes contribute to the checksum
          if ((k_q >= 6'd3) && (k_q <= 6'd34)) csum_d = csum_q + cur_byte;
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end else begin
          wait_d = (wait_q == ACK_TO) ? wait_q : wait_q + 16'd1;
          if (wait_d == ACK_TO) state_d = StAbort;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (k_q == LastIdx) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + 6'd1;
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      csum_q     <= '0;
      sig_q      <= '0;
      att_q      <= '0;
      med_q      <= '0;
      wait_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      csum_q     <= csum_d;
      sig_q      <= sig_d;
      att_q      <= att_d;
      med_q      <= med_d;
      wait_q     <= wait_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign err      = (state_q == StAbort);

endmodule

// File: tb/tb_big_packet_builder.sv
// Self-checking bench for big_packet_builder: UART responder model, frame capture,
// and a frame-level reference model built from the packet format rules.
module tb_big_packet_builder;

  localparam logic [7:0]  EEG_FILL = 8'h00;
  localparam logic [15:0] ACK_TO   = 16'd16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send = 1'b0;
  logic [7:0] signal_in = '0, attention_in = '0, meditation_in = '0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, busy, done, err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  big_packet_builder #(.EEG_FILL(EEG_FILL), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .send(send), .signal_in(signal_in), .attention_in(attention_in),
    .meditation_in(meditation_in), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done), .err(err)
  );

  // UART responder and bus monitor, sampled on the falling edge
  logic [7:0] cap[$];
  int  n_start = 0, n_done = 0, n_err = 0, n_consec = 0;
  int  cyc = 0, last_start_cyc = 0, err_cyc = 0, ucnt = 0;
  bit  prev_start = 1'b0, uart_en = 1'b1, rand_busy = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      n_start++;
      cap.push_back(tx_data);
      last_start_cyc = cyc;
      if (prev_start) n_consec++;
      if (uart_en) ucnt = rand_busy ? int'($urandom_range(12, 1)) : 10;
    end
    prev_start = tx_start;
    if (done) n_done++;
    if (err) begin n_err++; err_cyc = cyc; end
    tx_busy = (ucnt > 0);
    if (ucnt > 0) ucnt--;
  end

  // Reference frame: header, payload fields, 255 - (payload sum mod 256)
  logic [7:0] exp_pkt [36];
  task automatic build_model(input logic [7:0] s, input logic [7:0] a, input logic [7:0] m);
    logic [7:0] pl[$];
    int sum = 0;
    pl = {8'h02, s, 8'h83, 8'h18};
    for (int i = 0; i < 24; i++) pl.push_back(EEG_FILL);
    pl.push_back(8'h04); pl.push_back(a); pl.push_back(8'h05); pl.push_back(m);
    foreach (pl[i]) sum += int'(pl[i]);
    exp_pkt[0] = 8'hAA; exp_pkt[1] = 8'hAA; exp_pkt[2] = 8'h20;
    for (int i = 0; i < 32; i++) exp_pkt[3 + i] = pl[i];
    exp_pkt[35] = 8'(255 - (sum % 256));
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] a, input logic [7:0] m);
    @(negedge clk);
    signal_in = s; attention_in = a; meditation_in = m; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_end(input int target, output bit to);
    int i = 0;
    while ((n_done + n_err) < target && i < 3000) begin @(posedge clk); i++; end
    to = ((n_done + n_err) < target);
  endtask

  task automatic wait_starts(input int target, output bit to);
    int i = 0;
    while (n_start < target && i < 3000) begin @(posedge clk); i++; end
    to = (n_start < target);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else pass_cnt++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_nominal();
    int bs = cap.size(), bd = n_done, be = n_err;
    bit to;
    build_model(8'h00, 8'h50, 8'h3C);
    @(negedge clk);
    signal_in = 8'h00; attention_in = 8'h50; meditation_in = 8'h3C; send = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL latency_busy: got %b expected 1", busy); else pass_cnt++;
    total++; if (tx_start !== 1'b0) $display("FAIL latency_nostart: got %b expected 0", tx_start); else pass_cnt++;
    @(negedge clk) send = 1'b0;
    @(posedge clk); #1;
    total++; if (tx_start !== 1'b1) $display("FAIL latency_start: got %b expected 1", tx_start); else pass_cnt++;
    total++; if (tx_data !== 8'hAA) $display("FAIL latency_data: got %h expected aa", tx_data); else pass_cnt++;
    wait_end(bd + be + 1, to);
    total++; if (to) $display("FAIL nominal_timeout: got no end expected done"); else pass_cnt++;
    total++;
    if (cap.size() - bs !== 36) $display("FAIL nominal_count: got %0d expected 36", cap.size() - bs);
    else begin
      pass_cnt++;
      for (int i = 0; i < 36; i++) begin
        total++;
        if (cap[bs + i] !== exp_pkt[i])
          $display("FAIL nominal_byte%0d: got %h expected %h", i, cap[bs + i], exp_pkt[i]);
        else pass_cnt++;
      end
      total++; if (cap[bs + 35] !== 8'hCD) $display("FAIL nominal_csum: got %h expected cd", cap[bs + 35]); else pass_cnt++;
    end
    total++; if (n_done - bd !== 1) $display("FAIL nominal_done: got %0d expected 1", n_done - bd); else pass_cnt++;
    total++; if (n_err - be !== 0) $display("FAIL nominal_err: got %0d expected 0", n_err - be); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL nominal_busy_after: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_checksum_wrap();
    logic [7:0] ts [2] = '{8'hC8, 8'h00};
    logic [7:0] ta [2] = '{8'hFF, 8'h00};
    logic [7:0] tm [2] = '{8'hFF, 8'h00};
    logic [7:0] tc [2] = '{8'h93, 8'h59};
    for (int t = 0; t < 2; t++) begin
      int bs = cap.size();
      bit to;
      send_pkt(ts[t], ta[t], tm[t]);
      wait_end(n_done + n_err + 1, to);
      total++;
      if (to || cap.size() - bs !== 36) $display("FAIL csum%0d_count: got %0d expected 36", t, cap.size() - bs);
      else begin
        pass_cnt++;
        total++;
        if (cap[bs + 35] !== tc[t]) $display("FAIL csum%0d_value: got %h expected %h", t, cap[bs + 35], tc[t]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    rand_busy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [7:0] s = 8'($urandom), a = 8'($urandom), m = 8'($urandom);
      int bs = cap.size(), bd = n_done;
      bit to;
      build_model(s, a, m);
      send_pkt(s, a, m);
      wait_end(n_done + n_err + 1, to);
      total++;
      if (to || cap.size() - bs !== 36 || n_done - bd !== 1)
        $display("FAIL random%0d_frame: got %0d bytes expected 36", t, cap.size() - bs);
      else begin
        pass_cnt++;
        for (int i = 0; i < 36; i++) begin
          total++;
          if (cap[bs + i] !== exp_pkt[i])
            $display("FAIL random%0d_byte%0d: got %h expected %h", t, i, cap[bs + i], exp_pkt[i]);
          else pass_cnt++;
        end
      end
    end
    rand_busy = 1'b0;
  endtask

  // Host-side parse of the captured frame, as the receive path would see it
  task automatic test_loopback();
    int bs = cap.size();
    bit to;
    logic [7:0] ps = '0, pa = '0, pm = '0;
    int sum = 0, i = 0;
    send_pkt(8'h00, 8'h50, 8'h3C);
    wait_end(n_done + n_err + 1, to);
    total++;
    if (to || cap.size() - bs !== 36) $display("FAIL loop_count: got %0d expected 36", cap.size() - bs);
    else begin
      pass_cnt++;
      total++;
      if (cap[bs] !== 8'hAA || cap[bs + 1] !== 8'hAA || cap[bs + 2] !== 8'h20)
        $display("FAIL loop_header: got %h%h%h expected aaaa20", cap[bs], cap[bs + 1], cap[bs + 2]);
      else pass_cnt++;
      for (int j = 3; j < 35; j++) sum += int'(cap[bs + j]);
      total++;
      if (8'(255 - (sum % 256)) !== cap[bs + 35])
        $display("FAIL loop_csum: got %h expected %h", cap[bs + 35], 8'(255 - (sum % 256)));
      else pass_cnt++;
      while (i < 31) begin
        case (cap[bs + 3 + i])
          8'h02: begin ps = cap[bs + 4 + i]; i += 2; end
          8'h04: begin pa = cap[bs + 4 + i]; i += 2; end
          8'h05: begin pm = cap[bs + 4 + i]; i += 2; end
          8'h83: i += 2 + int'(cap[bs + 4 + i]);
          default: i++;
        endcase
      end
      total++;
      if ({ps, pa, pm} !== 24'h00503C) $display("FAIL loop_parse: got %h expected 00503c", {ps, pa, pm});
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    int bs = cap.size(), b0 = n_start, bd = n_done;
    bit to;
    build_model(8'h11, 8'h22, 8'h33);
    send_pkt(8'h11, 8'h22, 8'h33);
    wait_starts(b0 + 10, to);
    send_pkt(8'h99, 8'h88, 8'h77);
    wait_end(n_done + n_err + 1, to);
    repeat (60) @(posedge clk);
    total++; if (n_start - b0 !== 36) $display("FAIL ignore_starts: got %0d expected 36", n_start - b0); else pass_cnt++;
    total++; if (n_done - bd !== 1) $display("FAIL ignore_done: got %0d expected 1", n_done - bd); else pass_cnt++;
    if (cap.size() - bs >= 36)
      for (int i = 0; i < 36; i++) begin
        total++;
        if (cap[bs + i] !== exp_pkt[i])
          $display("FAIL ignore_byte%0d: got %h expected %h", i, cap[bs + i], exp_pkt[i]);
        else pass_cnt++;
      end
  endtask

  task automatic test_send_held();
    int bs = cap.size(), bd = n_done, i = 0;
    bit to;
    build_model(8'h42, 8'h17, 8'hE9);
    @(negedge clk);
    signal_in = 8'h42; attention_in = 8'h17; meditation_in = 8'hE9; send = 1'b1;
    while (n_done == bd && i < 3000) begin @(posedge clk); i++; end
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL held_restart: got busy %b expected 1", busy); else pass_cnt++;
    @(negedge clk) send = 1'b0;
    wait_end(bd + n_err + 2, to);
    total++;
    if (to || cap.size() - bs !== 72) $display("FAIL held_count: got %0d expected 72", cap.size() - bs);
    else begin
      pass_cnt++;
      for (int j = 0; j < 72; j++) begin
        total++;
        if (cap[bs + j] !== exp_pkt[j % 36])
          $display("FAIL held_byte%0d: got %h expected %h", j, cap[bs + j], exp_pkt[j % 36]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    int bs = cap.size(), b0 = n_start, bd = n_done, be = n_err;
    bit to;
    uart_en = 1'b0;
    send_pkt(8'h01, 8'h02, 8'h03);
    wait_end(bd + be + 1, to);
    total++; if (n_err - be !== 1) $display("FAIL timeout_err: got %0d expected 1", n_err - be); else pass_cnt++;
    total++; if (n_done - bd !== 0) $display("FAIL timeout_done: got %0d expected 0", n_done - bd); else pass_cnt++;
    total++; if (n_start - b0 !== 1) $display("FAIL timeout_starts: got %0d expected 1", n_start - b0); else pass_cnt++;
    total++;
    if (cap.size() - bs < 1 || cap[bs] !== 8'hAA) $display("FAIL timeout_byte: got none/other expected aa");
    else pass_cnt++;
    total++;
    if (err_cyc - last_start_cyc !== int'(ACK_TO))
      $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - last_start_cyc, ACK_TO);
    else pass_cnt++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL timeout_idle: got busy %b expected 0", busy); else pass_cnt++;
    uart_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int b0 = n_start, bd = n_done, be = n_err, bs, i = 0;
    bit to;
    send_pkt(8'h5A, 8'hA5, 8'h3C);
    // Stop on the cycle byte 20 is being issued
    while (!(tx_start === 1'b1 && n_start - b0 >= 20) && i < 3000) begin @(posedge clk); #1; i++; end
    #2 rst = 1'b0;
    #1;
    total++; if (tx_start !== 1'b0) $display("FAIL rstmid_tx_start: got %b expected 0", tx_start); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    i = 0;
    while (tx_busy && i < 100) begin @(posedge clk); i++; end
    repeat (5) @(posedge clk);
    total++; if (n_done - bd !== 0) $display("FAIL rstmid_done: got %0d expected 0", n_done - bd); else pass_cnt++;
    total++; if (n_err - be !== 0) $display("FAIL rstmid_err: got %0d expected 0", n_err - be); else pass_cnt++;
    bs = cap.size();
    build_model(8'h07, 8'h64, 8'h21);
    send_pkt(8'h07, 8'h64, 8'h21);
    wait_end(n_done + n_err + 1, to);
    total++;
    if (to || cap.size() - bs !== 36 || n_done - bd !== 1)
      $display("FAIL rstmid_fresh: got %0d bytes expected 36", cap.size() - bs);
    else begin
      pass_cnt++;
      for (int j = 0; j < 36; j++) begin
        total++;
        if (cap[bs + j] !== exp_pkt[j])
          $display("FAIL rstmid_byte%0d: got %h expected %h", j, cap[bs + j], exp_pkt[j]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    total++;
    if (n_consec !== 0) $display("FAIL start_adjacent: got %0d expected 0", n_consec); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_checksum_wrap();
    test_random();
    test_loopback();
    test_busy_ignore();
    test_send_held();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
